// File: rtl/video_decimator_pkg.sv
// Shared video constants and stream beat types.
// Used by the decimator and the video generator.
package video_decimator_pkg;

  localparam int unsigned AXIS_DATA_W = 32;
  localparam int unsigned VIDEO_W     = 640;
  localparam int unsigned VIDEO_H     = 480;

  typedef logic [AXIS_DATA_W-1:0] pixel_t;

  typedef struct packed {
    logic   tlast;
    logic   tuser;
    pixel_t tdata;
  } axis_beat_t;

  // A pixel survives 2:1 decimation only on even column and even row.
  function automatic logic keep_pixel(
    input logic x_lsb,
    input logic y_lsb
  );
    return !x_lsb && !y_lsb;
  endfunction

endpackage

// File: rtl/video_decimator_axis_reg_slice.sv
// One-deep AXI-Stream register for pixel plus tlast/tuser.
// Full throughput: reloads in the same cycle it drains.
module axis_reg_slice
  import video_decimator_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  axis_beat_t in_beat,
  output logic       out_valid,
  input  logic       out_ready,
  output axis_beat_t out_beat
);

  assign in_ready = !out_valid || out_ready;

  // Load on a write, drop valid after a transfer with no reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_beat  <= '0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      out_beat  <= in_beat;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/video_decimator.sv
// 2:1 horizontal and vertical video decimator.
// Tracks position from the input stream, keeps even x/y.
module video_decimator
  import video_decimator_pkg::*;
#(
  parameter int image_width = VIDEO_W,
  parameter int image_heigh = VIDEO_H
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   s_axis_tvalid,
  output logic                   s_axis_tready,
  input  logic [AXIS_DATA_W-1:0] s_axis_tdata,
  input  logic                   s_axis_tlast,
  input  logic                   s_axis_tuser,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [AXIS_DATA_W-1:0] m_axis_tdata,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tuser,
  output logic                   err_o
);

  localparam int XW = $clog2(image_width);
  localparam int YW = $clog2(image_heigh);

  localparam logic [XW-1:0] X_LAST  = XW'(image_width - 1);
  localparam logic [XW-1:0] X_OLAST = XW'(image_width - 2);
  localparam logic [YW-1:0] Y_LAST  = YW'(image_heigh - 1);

  logic [XW-1:0] x_q;
  logic [XW-1:0] x_cur;
  logic [XW-1:0] x_next;
  logic [YW-1:0] y_q;
  logic [YW-1:0] y_cur;
  logic [YW-1:0] y_next;

  logic       accept;
  logic       at_end;
  logic       line_end;
  logic       keep;
  logic       len_err;
  logic       err_q;
  logic       slice_ready;
  axis_beat_t in_beat;
  axis_beat_t out_beat;

  assign accept = s_axis_tvalid && slice_ready;

  // Start-of-frame overrides the counters for the beat that carries it.
  always_comb begin
    x_cur = x_q;
    y_cur = y_q;
    if (s_axis_tuser) begin
      x_cur = '0;
      y_cur = '0;
    end
  end

  assign at_end   = x_cur == X_LAST;
  assign line_end = s_axis_tlast || at_end;
  assign keep     = accept && keep_pixel(x_cur[0], y_cur[0]);
  assign len_err  = accept && (s_axis_tlast != at_end);

  // Advance position; a line ends on tlast or on the last column.
  always_comb begin
    x_next = x_q;
    y_next = y_q;
    if (accept) begin
      if (line_end) begin
        x_next = '0;
        y_next = (y_cur == Y_LAST) ? '0 : y_cur + YW'(1);
      end else begin
        x_next = x_cur + XW'(1);
        y_next = y_cur;
      end
    end
  end

  // Position counters and the one-cycle line-length error pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x_q   <= '0;
      y_q   <= '0;
      err_q <= 1'b0;
    end else begin
      x_q   <= x_next;
      y_q   <= y_next;
      err_q <= len_err;
    end
  end

  // Output markers refer to the decimated frame geometry.
  always_comb begin
    in_beat       = '0;
    in_beat.tdata = s_axis_tdata;
    in_beat.tuser = (x_cur == '0) && (y_cur == '0);
    in_beat.tlast = x_cur == X_OLAST;
  end

  axis_reg_slice u_slice (
    .clk       (clk_i),
    .rst       (rst_i),
    .in_valid  (keep),
    .in_ready  (slice_ready),
    .in_beat   (in_beat),
    .out_valid (m_axis_tvalid),
    .out_ready (m_axis_tready),
    .out_beat  (out_beat)
  );

  assign s_axis_tready = slice_ready;
  assign m_axis_tdata  = out_beat.tdata;
  assign m_axis_tlast  = out_beat.tlast;
  assign m_axis_tuser  = out_beat.tuser;
  assign err_o         = err_q;

endmodule

// File: tb/tb_video_decimator.sv
// Directed bench for video_decimator on an 8x4 frame.
// Monitor collects transfers and checks stall stability.
module tb_video_decimator;

  localparam int W = 8;
  localparam int H = 4;

  logic        clk;
  logic        rst_i;
  logic        s_tvalid;
  logic        s_tready;
  logic [31:0] s_tdata;
  logic        s_tlast;
  logic        s_tuser;
  logic        m_tvalid;
  logic        m_tready;
  logic [31:0] m_tdata;
  logic        m_tlast;
  logic        m_tuser;
  logic        err_o;

  int vecs = 0;
  int errs = 0;
  bit bp_en = 0;
  bit prev_stall = 0;
  logic [33:0] prev_beat = '0;
  logic [33:0] q[$];
  logic [33:0] exp_q[$];

  video_decimator #(
    .image_width (W),
    .image_heigh (H)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .s_axis_tvalid (s_tvalid),
    .s_axis_tready (s_tready),
    .s_axis_tdata  (s_tdata),
    .s_axis_tlast  (s_tlast),
    .s_axis_tuser  (s_tuser),
    .m_axis_tvalid (m_tvalid),
    .m_axis_tready (m_tready),
    .m_axis_tdata  (m_tdata),
    .m_axis_tlast  (m_tlast),
    .m_axis_tuser  (m_tuser),
    .err_o         (err_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pix(input int x, input int y);
    return 32'hC0DE_0000 | 32'(y << 8) | 32'(x);
  endfunction

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l,
                      input logic u);
    int n;
    n = 0;
    s_tvalid = 1'b1;
    s_tdata  = d;
    s_tlast  = l;
    s_tuser  = u;
    @(negedge clk);
    while (!s_tready && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (n >= 64) begin
      vecs++;
      errs++;
      $error("FAIL send_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk);
    #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
  endtask

  task automatic send_row(input int y, input int x0, input bit sof);
    for (int x = x0; x < W; x++)
      send(pix(x, y), x == W - 1, sof && x == x0);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic add_row(input int y, input bit sof);
    for (int i = 0; i < W / 2; i++)
      exp_q.push_back({i == W / 2 - 1, sof && i == 0, pix(2 * i, y)});
  endtask

  task automatic compare_q(input string tag);
    check({tag, "_len"}, 64'(q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < q.size(); i++)
      check(tag, 64'(q[i]), 64'(exp_q[i]));
    q.delete();
    exp_q.delete();
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) m_tready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_i) begin
        prev_stall = 0;
      end else begin
        if (prev_stall)
          check("stall_hold", {m_tvalid, m_tlast, m_tuser, m_tdata},
                {1'b1, prev_beat});
        if (m_tvalid && m_tready) q.push_back({m_tlast, m_tuser, m_tdata});
        prev_stall = m_tvalid && !m_tready;
        prev_beat  = {m_tlast, m_tuser, m_tdata};
      end
    end
  end

  initial begin
    rst_i    = 1'b1;
    s_tvalid = 1'b0;
    s_tdata  = '0;
    s_tlast  = 1'b0;
    s_tuser  = 1'b0;
    m_tready = 1'b1;
    #3;
    check("rst_out", {m_tvalid, m_tlast, m_tuser, err_o, m_tdata}, 64'd0);
    check("rst_rdy", s_tready, 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    check("post_rst_rdy", s_tready, 1);

    // nominal frame, no backpressure
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        send(pix(x, y), x == W - 1, x == 0 && y == 0);
        if (x % 2 == 0 && y % 2 == 0)
          check("nom_keep", {err_o, m_tvalid, m_tlast, m_tuser, m_tdata},
                {1'b0, 1'b1, x == W - 2, x == 0 && y == 0, pix(x, y)});
        else
          check("nom_drop", {err_o, m_tvalid}, 2'b00);
      end
    end
    idle(2);
    add_row(0, 1);
    add_row(2, 0);
    compare_q("nom_q");

    // random backpressure, same output sequence
    bp_en = 1;
    for (int y = 0; y < H; y++) send_row(y, 0, y == 0);
    bp_en = 0;
    m_tready = 1'b1;
    idle(4);
    add_row(0, 1);
    add_row(2, 0);
    compare_q("bp_q");

    // short line: tlast at x=3 on row 1
    send_row(0, 0, 1);
    for (int x = 0; x < 4; x++) send(pix(x, 1), x == 3, 1'b0);
    check("short_err_on", err_o, 1);
    send(pix(0, 2), 1'b0, 1'b0);
    check("short_err_off", err_o, 0);
    check("short_next_x0", {m_tvalid, m_tuser, m_tdata},
          {1'b1, 1'b0, pix(0, 2)});
    send_row(2, 1, 0);
    send_row(3, 0, 0);
    idle(2);
    add_row(0, 1);
    add_row(2, 0);
    compare_q("short_q");

    // missing tlast at x=7 on row 1, then y wraps into a new frame
    send_row(0, 0, 1);
    for (int x = 0; x < W; x++) send(pix(x, 1), 1'b0, 1'b0);
    check("miss_err_on", err_o, 1);
    send(pix(0, 2), 1'b0, 1'b0);
    check("miss_err_off", err_o, 0);
    check("miss_next_x0", {m_tvalid, m_tuser, m_tdata},
          {1'b1, 1'b0, pix(0, 2)});
    send_row(2, 1, 0);
    send_row(3, 0, 0);
    send(pix(0, 0), 1'b0, 1'b0);
    check("wrap_sof", {m_tvalid, m_tuser, m_tlast, m_tdata},
          {1'b1, 1'b1, 1'b0, pix(0, 0)});
    idle(2);
    add_row(0, 1);
    add_row(2, 0);
    exp_q.push_back({1'b0, 1'b1, pix(0, 0)});
    compare_q("miss_q");

    // mid-frame resync on row 2
    send_row(0, 1, 0);
    send_row(1, 0, 0);
    for (int x = 0; x < 3; x++) send(pix(x, 2), 1'b0, 1'b0);
    send(pix(0, 0), 1'b0, 1'b1);
    check("resync_sof", {m_tvalid, m_tuser, m_tlast, m_tdata},
          {1'b1, 1'b1, 1'b0, pix(0, 0)});
    send_row(0, 1, 0);
    for (int y = 1; y < H; y++) send_row(y, 0, 0);
    idle(2);
    for (int i = 1; i < W / 2; i++)
      exp_q.push_back({i == W / 2 - 1, 1'b0, pix(2 * i, 0)});
    exp_q.push_back({1'b0, 1'b0, pix(0, 2)});
    exp_q.push_back({1'b0, 1'b0, pix(2, 2)});
    add_row(0, 1);
    add_row(2, 0);
    compare_q("resync_q");

    // reset while an output beat is held
    m_tready = 1'b0;
    send(pix(0, 0), 1'b0, 1'b1);
    check("held_valid", m_tvalid, 1);
    #2;
    rst_i = 1'b1;
    #1;
    check("rst_async", {m_tvalid, m_tlast, m_tuser, err_o, m_tdata}, 64'd0);
    check("rst_async_rdy", s_tready, 1);
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    m_tready = 1'b1;
    q.delete();
    for (int y = 0; y < H; y++) send_row(y, 0, y == 0);
    idle(2);
    add_row(0, 1);
    add_row(2, 0);
    compare_q("rst_q");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
